// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: FSM encoding, default widths and command record layout for the ALU issue queue.
package alu_issue_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int OP_W_DEF    = 4;
  localparam int DEPTH_DEF   = 4;
  localparam int ALU_LAT_DEF = 1;
  localparam int CNT_W_DEF   = 16;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  // Command record is packed as {op, b, a}, a in the LSBs.
  function automatic int cmd_w(input int data_w, input int op_w);
    return 2 * data_w + op_w;
  endfunction
endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: command, ALU-pin and result bundle; slave is the issue queue, master its environment.
interface alu_issue_if import alu_issue_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
);
  logic              cmd_valid, cmd_ready;
  logic [DATA_W-1:0] cmd_a, cmd_b;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_r;
  logic [OP_W-1:0]   alu_op;
  logic              alu_z;
  logic              res_valid, res_ready, res_zero, busy;
  logic [DATA_W-1:0] res_data;
  logic [OP_W-1:0]   res_op;
  modport master(
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_r, alu_z, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_zero, res_op, busy
  );
  modport slave(
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_r, alu_z, res_ready,
    output cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_zero, res_op, busy
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module alu_cmd_fifo import alu_issue_pkg::*; #(
  parameter int W     = cmd_w(DATA_W_DEF, OP_W_DEF),
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = wptr == rptr;
  assign dout  = mem[rptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (AW+1)'(1);
      if (pop && !empty) rptr <= rptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffers ALU commands, issues one at a time, returns r/z on a valid/ready port.
// Optional statistics counters are enabled with ALU_ISSUE_STATS_EN.
module alu_issue_queue import alu_issue_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ALU_LAT = ALU_LAT_DEF
`ifdef ALU_ISSUE_STATS_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus
`ifdef ALU_ISSUE_STATS_EN
  , output logic [CNT_W-1:0] stat_issued
  , output logic [CNT_W-1:0] stat_zero
`endif
);
  localparam int CW = $clog2(ALU_LAT + 2);
  localparam int FW = cmd_w(DATA_W, OP_W);
  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [FW-1:0] head;
  logic          full, empty, pop, accept, capture;
  alu_cmd_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (bus.cmd_valid && !full),
    .pop  (pop),
    .din  ({bus.cmd_op, bus.cmd_b, bus.cmd_a}),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  assign bus.cmd_ready = !full;
  assign bus.busy      = state != IDLE || !empty;
  assign accept        = state == HOLD && bus.res_ready;
  assign capture       = state == WAIT && cnt == '0;
  always_comb begin
    pop     = !empty && (state == IDLE || accept);
    state_n = pop ? WAIT : capture ? HOLD : accept ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // ALU pins only change on a pop, so they hold the last issued command between commands.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt           <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_op    <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_zero  <= 1'b0;
      bus.res_op    <= '0;
    end else begin
      if (pop) begin
        {bus.alu_op, bus.alu_b, bus.alu_a} <= head;
        cnt <= CW'(ALU_LAT);
      end else if (state == WAIT && cnt != '0) cnt <= cnt - CW'(1);
      if (capture) begin
        bus.res_data  <= bus.alu_r;
        bus.res_zero  <= bus.alu_z;
        bus.res_op    <= bus.alu_op;
        bus.res_valid <= 1'b1;
      end else if (accept) bus.res_valid <= 1'b0;
    end
`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_issued <= '0;
      stat_zero   <= '0;
    end else begin
      if (pop && !(&stat_issued)) stat_issued <= stat_issued + CNT_W'(1);
      if (accept && bus.res_zero && !(&stat_zero)) stat_zero <= stat_zero + CNT_W'(1);
    end
`endif
endmodule
